// File: rtl/blram_arbiter.sv
// blram_arbiter: two-port round-robin arbiter/sequencer in front of a
// single-port 16-bit block RAM with 1-cycle registered read.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_req_x/i_we_x/i_addr_x/i_wdata_x   request from port x (A = CPU, B = loader)
//   o_ack_x/o_rdata_x        one-cycle completion pulse with read data
//   o_err_b                  pulses with o_ack_b when a port-B write was blocked
//   o_ram_we/o_ram_addr/o_ram_wdata      registered RAM command
//   i_ram_rdata              RAM read data (valid in RESP)
//   o_busy                   FSM not idle
//
// Optional feature: define BLRAM_ARB_WPROT_EN to block port-B writes to
// addresses below PROT_BOUND (issued as reads, completed with o_err_b=1).
module blram_arbiter #(
  parameter int unsigned          SIZE       = 13,
  parameter logic [SIZE-1:0]      PROT_BOUND = SIZE'(64)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_a,
  input  logic            i_we_a,
  input  logic [SIZE-1:0] i_addr_a,
  input  logic [15:0]     i_wdata_a,
  output logic            o_ack_a,
  output logic [15:0]     o_rdata_a,
  input  logic            i_req_b,
  input  logic            i_we_b,
  input  logic [SIZE-1:0] i_addr_b,
  input  logic [15:0]     i_wdata_b,
  output logic            o_ack_b,
  output logic [15:0]     o_rdata_b,
  output logic            o_err_b,
  output logic            o_ram_we,
  output logic [SIZE-1:0] o_ram_addr,
  output logic [15:0]     o_ram_wdata,
  input  logic [15:0]     i_ram_rdata,
  output logic            o_busy
);

`ifdef BLRAM_ARB_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic            ram_we_q, ram_we_d;
  logic [SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]     ram_wdata_q, ram_wdata_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;
  logic            err_b_q, err_b_d;
  logic [15:0]     rdata_a_q, rdata_a_d;
  logic [15:0]     rdata_b_q, rdata_b_d;
  logic            last_grant_q, last_grant_d;  // 1 = port B
  logic            winner_q, winner_d;          // 1 = port B
  logic            blocked_q, blocked_d;

  logic elig_a, elig_b, grant_b, prot_hit;

  always_comb begin
    state_d      = state_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    err_b_d      = 1'b0;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    blocked_d    = blocked_q;

    // A port is ineligible in its own ack cycle so a held request is not re-issued.
    elig_a   = i_req_a & ~ack_a_q;
    elig_b   = i_req_b & ~ack_b_q;
    // B wins if alone, or on contention when A was granted last.
    grant_b  = elig_b & (~elig_a | ~last_grant_q);
    prot_hit = WPROT && i_we_b && (i_addr_b < PROT_BOUND);

    unique case (state_q)
      IDLE: begin
        ram_we_d = 1'b0;
        if (elig_a | elig_b) begin
          state_d  = ACCESS;
          winner_d = grant_b;
          if (grant_b) begin
            ram_addr_d  = i_addr_b;
            ram_wdata_d = i_wdata_b;
            ram_we_d    = i_we_b & ~prot_hit;
            blocked_d   = prot_hit;
          end else begin
            ram_addr_d  = i_addr_a;
            ram_wdata_d = i_wdata_a;
            ram_we_d    = i_we_a;
            blocked_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        ram_we_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (winner_q) begin
          rdata_b_d = i_ram_rdata;
          ack_b_d   = 1'b1;
          err_b_d   = blocked_q;
        end else begin
          rdata_a_d = i_ram_rdata;
          ack_a_d   = 1'b1;
        end
        last_grant_d = winner_q;
        state_d      = IDLE;
      end
      default: begin
        ram_we_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      err_b_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      blocked_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      err_b_q      <= err_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      blocked_q    <= blocked_d;
    end
  end

  assign o_ack_a     = ack_a_q;
  assign o_ack_b     = ack_b_q;
  assign o_err_b     = err_b_q;
  assign o_rdata_a   = rdata_a_q;
  assign o_rdata_b   = rdata_b_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_blram_arbiter.sv
module tb_blram_arbiter;
  localparam int SIZE = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_req_a = 1'b0, i_we_a = 1'b0;
  logic [SIZE-1:0] i_addr_a = '0;
  logic [15:0]     i_wdata_a = '0;
  logic            i_req_b = 1'b0, i_we_b = 1'b0;
  logic [SIZE-1:0] i_addr_b = '0;
  logic [15:0]     i_wdata_b = '0;
  logic            o_ack_a, o_ack_b, o_err_b, o_ram_we, o_busy;
  logic [15:0]     o_rdata_a, o_rdata_b, o_ram_wdata;
  logic [SIZE-1:0] o_ram_addr;
  logic [15:0]     ram_rdata = '0;

  logic [15:0] mem [0:(1<<SIZE)-1];

  int total = 0, bad = 0;
  int cyc = 0;
  int we_cnt = 0, busy_rises = 0;
  logic [SIZE-1:0] we_addr = '0;
  logic busy_prev = 1'b0;
  logic [16:0] exp_a[$], exp_b[$];   // {err, rdata}
  int ack_port[$], ack_cyc[$];

  blram_arbiter #(.SIZE(SIZE), .PROT_BOUND(13'd64)) dut (
    .clk(clk), .rst(rst),
    .i_req_a(i_req_a), .i_we_a(i_we_a), .i_addr_a(i_addr_a), .i_wdata_a(i_wdata_a),
    .o_ack_a(o_ack_a), .o_rdata_a(o_rdata_a),
    .i_req_b(i_req_b), .i_we_b(i_we_b), .i_addr_b(i_addr_b), .i_wdata_b(i_wdata_b),
    .o_ack_b(o_ack_b), .o_rdata_b(o_rdata_b), .o_err_b(o_err_b),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(ram_rdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Block RAM model: registered read of old data, write on we.
  always @(posedge clk) begin
    ram_rdata <= mem[o_ram_addr];
    if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk) begin
    if (rst) begin
      if (o_ack_a) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack_a got=1 exp=0");
        end else begin
          logic [16:0] e;
          e = exp_a.pop_front();
          check("rdata_a", {16'h0, o_rdata_a}, {16'h0, e[15:0]});
        end
        ack_port.push_back(0); ack_cyc.push_back(cyc);
      end
      if (o_ack_b) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack_b got=1 exp=0");
        end else begin
          logic [16:0] e;
          e = exp_b.pop_front();
          check("rdata_b", {16'h0, o_rdata_b}, {16'h0, e[15:0]});
          check("err_b", {31'h0, o_err_b}, {31'h0, e[16]});
        end
        ack_port.push_back(1); ack_cyc.push_back(cyc);
      end else if (o_err_b) begin
        total++; bad++;
        $display("FAIL err_without_ack got=1 exp=0");
      end
      if (o_ram_we) begin
        we_cnt++;
        we_addr = o_ram_addr;
      end
      if (o_busy && !busy_prev) busy_rises++;
      busy_prev = o_busy;
    end
  end

  task automatic wait_ack(input bit port_b, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port_b ? o_ack_b : o_ack_a) && n < 30);
    if (!(port_b ? o_ack_b : o_ack_a)) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_ack exp=ack", name);
    end
  endtask

  task automatic do_a(input logic we, input logic [SIZE-1:0] addr, input logic [15:0] wd,
                      input logic [15:0] exp_rd, input bit hold);
    @(posedge clk); #1;
    exp_a.push_back({1'b0, exp_rd});
    i_req_a = 1'b1; i_we_a = we; i_addr_a = addr; i_wdata_a = wd;
    wait_ack(1'b0, "ack_a");
    if (hold) begin @(posedge clk); #1; end
    i_req_a = 1'b0; i_we_a = 1'b0;
  endtask

  task automatic do_b(input logic we, input logic [SIZE-1:0] addr, input logic [15:0] wd,
                      input logic [15:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    exp_b.push_back({exp_err, exp_rd});
    i_req_b = 1'b1; i_we_b = we; i_addr_b = addr; i_wdata_b = wd;
    wait_ack(1'b1, "ack_b");
    i_req_b = 1'b0; i_we_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, b0;
    for (int i = 0; i < (1 << SIZE); i++) mem[i] = 16'h0000;
    mem[5]  = 16'hBEEF;
    mem[7]  = 16'h0001;
    mem[10] = 16'h00AA;

    // Reset state
    #1;
    check("rst_ram_we", {31'h0, o_ram_we}, 0);
    check("rst_ram_addr", {19'h0, o_ram_addr}, 0);
    check("rst_acks", {29'h0, o_ack_a, o_ack_b, o_err_b}, 0);
    check("rst_rdata", {o_rdata_a, o_rdata_b}, 0);
    check("rst_busy", {31'h0, o_busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single A read of 5, cycle-exact
    w0 = we_cnt;
    @(posedge clk); #1;
    exp_a.push_back({1'b0, 16'hBEEF});
    i_req_a = 1'b1; i_addr_a = 13'd5;
    @(posedge clk); #1;   // after T0
    check("t1_busy", {31'h0, o_busy}, 1);
    check("t1_addr", {19'h0, o_ram_addr}, 5);
    check("t1_we", {31'h0, o_ram_we}, 0);
    @(posedge clk); #1;   // after T1
    check("t2_noack", {31'h0, o_ack_a}, 0);
    @(posedge clk); #1;   // after T2
    check("t3_ack_a", {31'h0, o_ack_a}, 1);
    i_req_a = 1'b0;
    @(negedge clk);
    check("read_no_we", we_cnt - w0, 0);

    // Single B write then A read back
    w0 = we_cnt;
    do_b(1'b1, 13'd100, 16'h1234, 16'h0000, 1'b0);
    check("bwr_we_pulses", we_cnt - w0, 1);
    check("bwr_we_addr", {19'h0, we_addr}, 100);
    do_a(1'b0, 13'd100, 16'h0, 16'h1234, 1'b0);

    // A write returns old data; readback
    do_a(1'b1, 13'd20, 16'h5555, 16'h0000, 1'b0);
    do_a(1'b0, 13'd20, 16'h0, 16'h5555, 1'b0);

    // Request held through ack cycle: only one access
    b0 = busy_rises;
    do_a(1'b0, 13'd5, 16'h0, 16'hBEEF, 1'b1);
    repeat (4) @(posedge clk);
    check("hold_one_access", busy_rises - b0, 1);

    // Contention from reset: A,B,A,B at 3-cycle spacing
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ack_port.delete(); ack_cyc.delete();
    fork
      begin
        do_a(1'b0, 13'd5, 16'h0, 16'hBEEF, 1'b0);
        do_a(1'b0, 13'd20, 16'h0, 16'h5555, 1'b0);
      end
      begin
        do_b(1'b0, 13'd100, 16'h0, 16'h1234, 1'b0);
        do_b(1'b0, 13'd5, 16'h0, 16'hBEEF, 1'b0);
      end
    join
    repeat (4) @(posedge clk);
    check("cont_ack_count", ack_port.size(), 4);
    if (ack_port.size() == 4) begin
      check("cont_order", {28'h0, ack_port[0][0], ack_port[1][0], ack_port[2][0], ack_port[3][0]}, 32'h5);
      check("cont_gap1", ack_cyc[1] - ack_cyc[0], 3);
      check("cont_gap2", ack_cyc[2] - ack_cyc[1], 3);
      check("cont_gap3", ack_cyc[3] - ack_cyc[2], 3);
    end

    // Reset during ACCESS of a write to 7
    @(posedge clk); #1;
    i_req_b = 1'b1; i_we_b = 1'b1; i_addr_b = 13'd7; i_wdata_b = 16'hDEAD;
    @(posedge clk); #1;
    check("abort_we_before", {31'h0, o_ram_we}, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_we_async", {31'h0, o_ram_we}, 0);
    check("abort_idle", {31'h0, o_busy}, 0);
    i_req_b = 1'b0; i_we_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk) check("abort_no_ack", {30'h0, o_ack_a, o_ack_b}, 0);
    check("abort_mem7", {16'h0, mem[7]}, 32'h0001);
    do_b(1'b0, 13'd7, 16'h0, 16'h0001, 1'b0);

`ifdef BLRAM_ARB_WPROT_EN
    w0 = we_cnt;
    do_b(1'b1, 13'd10, 16'hFFFF, 16'h00AA, 1'b1);
    check("prot_no_we", we_cnt - w0, 0);
    do_b(1'b0, 13'd10, 16'h0, 16'h00AA, 1'b0);
    w0 = we_cnt;
    do_b(1'b1, 13'd64, 16'h7777, 16'h0000, 1'b0);
    check("bound_we", we_cnt - w0, 1);
    do_a(1'b1, 13'd3, 16'h3333, 16'h0000, 1'b0);
    do_a(1'b0, 13'd64, 16'h0, 16'h7777, 1'b0);
    do_b(1'b0, 13'd3, 16'h0, 16'h3333, 1'b0);
`else
    w0 = we_cnt;
    do_b(1'b1, 13'd10, 16'hFFFF, 16'h00AA, 1'b0);
    check("noprot_we", we_cnt - w0, 1);
    do_a(1'b0, 13'd10, 16'h0, 16'hFFFF, 1'b0);
`endif

    repeat (4) @(posedge clk);
    check("sb_empty", exp_a.size() + exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blram_arbiter.md
Name: blram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 16-bit block RAM (blram: registered read, 1-cycle latency, write on i_we).
- Port A serves the CPU; port B serves the loader/debug requester.
- Round-robin arbitration; one RAM access in flight at a time.
- Every RAM control signal is driven from a register; each access is returned to its requester as a one-cycle ack with data.

Parameters:
- SIZE, 13, RAM address width (matches blram SIZE).
- PROT_BOUND, 13'd64, port-B writes to addresses below this are blocked when BLRAM_ARB_WPROT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_req_a  input  1  port A request; held until o_ack_a.
- i_we_a  input  1  port A write enable, qualified by i_req_a.
- i_addr_a  input  SIZE  port A address.
- i_wdata_a  input  16  port A write data.
- o_ack_a  output  1  one-cycle completion pulse for port A.
- o_rdata_a  output  16  port A read data, valid while o_ack_a=1.
- i_req_b, i_we_b, i_addr_b, i_wdata_b, o_ack_b, o_rdata_b: same as port A, for port B.
- o_err_b  output  1  pulses with o_ack_b when a port-B write was blocked.
- o_ram_we  output  1  to blram i_we.
- o_ram_addr  output  SIZE  to blram i_addr.
- o_ram_wdata  output  16  to blram i_ram_data_in.
- i_ram_rdata  input  16  from blram o_ram_data_out.
- o_busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - o_ram_we, o_ram_addr, o_ram_wdata = 0.
  - o_ack_a, o_ack_b, o_err_b = 0.
  - o_rdata_a, o_rdata_b = 0.
  - last_grant=B, so port A wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE, no eligible request: remain in IDLE; o_ram_we=0.
  - IDLE, at least one eligible request, on the clock edge:
    - choose the winner;
    - register o_ram_addr, o_ram_wdata, and o_ram_we = winner's we;
    - record the winner;
    - go to ACCESS.
  - ACCESS: the RAM samples the command on the edge ending this cycle. On that edge:
    - o_ram_we is cleared to 0;
    - state goes to RESP.
    - o_ram_we is therefore high for exactly one cycle per write.
  - RESP: i_ram_rdata is valid. On the edge ending this cycle:
    - o_rdata_<winner> is loaded from i_ram_rdata (for writes this is the pre-write old data);
    - o_ack_<winner> is set for one cycle;
    - last_grant = winner;
    - state goes to IDLE.
- Eligibility: a port is ineligible in any cycle where its own o_ack is high. This blocks re-issue of the just-completed request; the requester drops or changes its req in the ack cycle.
- Arbitration:
  - Only one port eligible: that port wins.
  - Both ports eligible: the port opposite last_grant wins (strict alternation under continuous contention).
- Latency: request sampled at edge T0, ack visible in the cycle after edge T2 (3 cycles). Maximum rate is one access per 3 cycles.
- Requests arriving while the FSM is in ACCESS or RESP are held by the requester, not dropped.
- The other port's outputs are unchanged during an access; o_rdata_x holds its last value.
- Address is passed through unmodified; no wrap logic (SIZE bits cover DEPTH).
- Reset during ACCESS with o_ram_we=1: o_ram_we drops immediately. If reset asserts before the clock edge, the RAM write does not occur. No ack is ever issued for an access aborted by reset.

Optional Feature:
- Macro: BLRAM_ARB_WPROT_EN.
- Defined:
  - A port-B write with address < PROT_BOUND is issued with o_ram_we=0 (converted to a read).
  - It completes normally with o_ack_b=1 and o_err_b=1 in the same cycle.
  - Port A is never blocked.
- Undefined: no protection; o_err_b is constantly 0.

Test Plan:
- Reset then single A read: memory[5]=16'hBEEF, i_req_a=1, i_addr_a=5 at T0 → o_ram_addr=5 at T1, o_ack_a=1 and o_rdata_a=16'hBEEF in the cycle after T2; o_ram_we never 1.
- Single B write: i_req_b=1, i_we_b=1, i_addr_b=100, i_wdata_b=16'h1234 → o_ram_we=1 for exactly one cycle with o_ram_addr=100; o_ack_b pulses; a subsequent A read of 100 returns 16'h1234.
- Contention: A and B both request continuously from reset → grant order A,B,A,B; acks spaced 3 cycles; no double ack for the same request.
- Ack-cycle rule: requester keeps req high one cycle past ack → that cycle is ignored; only one access is recorded.
- Reset mid-access: rst low during ACCESS of a write to addr 7 (old 16'h0001) → o_ram_we=0 asynchronously, FSM in IDLE, no ack, memory[7] still 16'h0001.
- BLRAM_ARB_WPROT_EN defined: B write addr 10, data 16'hFFFF → o_ram_we stays 0, o_ack_b=1, o_err_b=1, memory[10] unchanged. B write addr 64 → succeeds with o_err_b=0.
